// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for serial_subtractor.
// Optional signed-overflow flag present when SERIAL_SUB_OVERFLOW_EN is defined.
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             ovf;

  modport master (output start, A, B, input busy, done, diff, borrow, ovf);
  modport slave  (input start, A, B, output busy, done, diff, borrow, ovf);
`else
  modport master (output start, A, B, input busy, done, diff, borrow);
  modport slave  (input start, A, B, output busy, done, diff, borrow);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = A - B, computed LSB-first as
// A + ~B + 1 through a single full-adder slice over WIDTH cycles.
// Optional macro SERIAL_SUB_OVERFLOW_EN adds a signed-overflow flag (ovf).
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_subtractor_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             s;
  logic             cout;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             ovf_q, ovf_d;
`endif

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_q    <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_q    <= res_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  // Next-state logic: accept in IDLE, one full-adder slice per CALC cycle.
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_d    = res_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif
    s    = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    cout = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_sr_d  = bus.A;
          b_sr_d  = ~bus.B;
          carry_d = 1'b1;
          cnt_d   = '0;
          state_d = S_CALC;
`ifdef SERIAL_SUB_OVERFLOW_EN
          a_msb_d = bus.A[WIDTH-1];
          b_msb_d = bus.B[WIDTH-1];
`endif
        end
      end
      S_CALC: begin
        carry_d = cout;
        res_d   = {s, res_q[WIDTH-1:1]};
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // Final slice: publish the result including the bit produced this cycle.
          diff_d   = {s, res_q[WIDTH-1:1]};
          borrow_d = ~cout;
          state_d  = S_DONE;
`ifdef SERIAL_SUB_OVERFLOW_EN
          ovf_d    = (a_msb_q != b_msb_q) && (s != a_msb_q);
`endif
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.busy   = (state_q == S_CALC);
  assign bus.done   = (state_q == S_DONE);
  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
  assign bus.ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH = 4) using a result scoreboard.
module tb_serial_subtractor;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   done_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.diff   = a - b;
    e.borrow = (a < b);
    e.ovf    = (a[W-1] != b[W-1]) && (e.diff[W-1] != a[W-1]);
    return e;
  endfunction

  // Compare every completion against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.done) begin
      done_cnt++;
      if (sb_q.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("diff", 32'(bus.diff), 32'(e.diff));
        check("borrow", 32'(bus.borrow), 32'(e.borrow));
`ifdef SERIAL_SUB_OVERFLOW_EN
        check("ovf", 32'(bus.ovf), 32'(e.ovf));
`endif
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((bus.busy || bus.done) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy || bus.done) check("idle_timeout", 32'd0, 32'd1);
  endtask

  // Launch one operation from IDLE; reports negedges until done and busy cycles seen.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int busy_cyc);
    int n = 0;
    busy_cyc = 0;
    wait_idle();
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    sb_q.push_back(model(a, b));
    do begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.A     = $urandom_range(0, 15);
      bus.B     = $urandom_range(0, 15);
      n++;
      if (bus.busy) busy_cyc++;
    end while (!bus.done && n < 20);
    if (!bus.done) check("done_timeout", 32'd0, 32'd1);
    lat = n;
  endtask

  initial begin
    int lat, bc, dc;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;

    #12;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_diff", 32'(bus.diff), 32'd0);
    check("rst_borrow", 32'(bus.borrow), 32'd0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    check("rst_ovf", 32'(bus.ovf), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    run_op(4'd9, 4'd3, lat, bc);
    check("latency", 32'(lat), 32'(W + 1));
    check("busy_cycles", 32'(bc), 32'(W));

    run_op(4'd3, 4'd9, lat, bc);
    run_op(4'd0, 4'd0, lat, bc);
    run_op(4'd15, 4'd15, lat, bc);
    run_op(4'd0, 4'd1, lat, bc);

`ifdef SERIAL_SUB_OVERFLOW_EN
    run_op(4'd8, 4'd1, lat, bc);
    run_op(4'd7, 4'd15, lat, bc);
    run_op(4'd6, 4'd2, lat, bc);
`endif

    // Starts presented during CALC and DONE must not launch extra operations.
    wait_idle();
    dc = done_cnt;
    bus.A     = 4'd5;
    bus.B     = 4'd2;
    bus.start = 1'b1;
    sb_q.push_back(model(4'd5, 4'd2));
    for (int i = 0; i < 20 && !bus.done; i++) begin
      @(negedge clk);
      bus.A     = 4'd1;
      bus.B     = 4'd7;
      bus.start = 1'b1;
    end
    check("ign_done_seen", 32'(bus.done), 32'd1);
    @(negedge clk);
    bus.start = 1'b0;
    check("ign_after_done_busy", 32'(bus.busy), 32'd0);
    repeat (8) @(negedge clk);
    check("ign_single_done", 32'(done_cnt - dc), 32'd1);
    check("ign_stays_idle", 32'(bus.busy), 32'd0);

    // Asynchronous reset in the middle of CALC abandons the operation.
    wait_idle();
    dc = done_cnt;
    bus.A     = 4'd12;
    bus.B     = 4'd4;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_done", 32'(bus.done), 32'd0);
    check("arst_diff", 32'(bus.diff), 32'd0);
    check("arst_borrow", 32'(bus.borrow), 32'd0);
    repeat (8) @(negedge clk);
    check("arst_no_done", 32'(done_cnt - dc), 32'd0);
    rst_n = 1'b1;
    run_op(4'd12, 4'd4, lat, bc);

    // Back-to-back random operations, each launched in the first IDLE cycle.
    for (int i = 0; i < 200; i++) begin
      run_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), lat, bc);
      check("rand_latency", 32'(lat), 32'(W + 1));
    end

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
